// File: rtl/mips_pkg.sv
// mips_pkg: shared pipeline types for decode, ID/EX and EX/MEM.
//   alu_op_t : 3-bit ALU operation class
//   ctrl_t   : packed control bits carried down the pipeline
//   REG_ZERO : architectural register $0 (hardwired zero)
package mips_pkg;
   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_LUI, ALU_FUNCT
   } alu_op_t;
   typedef struct packed {
      logic    regWrite;
      logic    memRead;
      logic    memWrite;
      logic    memToReg;
      logic    aluSrc;
      logic    regDst;
      alu_op_t aluOp;
   } ctrl_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard check between EX and ID.
//   inputs : valid_ex, mem_read_ex, rt_ex (load in EX and its destination),
//            valid_id, rs_id, rt_id, uses_rt_id (sources of the decode slot),
//            flush, hold (both suppress the stall)
//   output : load_use_stall
module load_use_detect
   import mips_pkg::*;
(
   input  logic       valid_ex,
   input  logic       mem_read_ex,
   input  logic [4:0] rt_ex,
   input  logic       valid_id,
   input  logic [4:0] rs_id,
   input  logic [4:0] rt_id,
   input  logic       uses_rt_id,
   input  logic       flush,
   input  logic       hold,
   output logic       load_use_stall
);
   logic srcMatch;
   assign srcMatch = (rt_ex == rs_id) | (uses_rt_id & (rt_ex == rt_id));
   // A flushed instruction must not freeze fetch; during hold the check is
   // simply deferred to the first non-hold cycle.
   assign load_use_stall = valid_ex & mem_read_ex & valid_id & (rt_ex != REG_ZERO)
                         & srcMatch & ~flush & ~hold;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble, flush and hold.
//   params : DW data width; CNT_W counter width (ID_EX_PERF_EN only)
//   inputs : clk, rst (async, active-high), valid_id, *_id operand/specifier/
//            control fields, uses_rt_id, flush, hold
//   outputs: registered *_ex copies, valid_ex, load_use_stall,
//            bubble_cnt/flush_cnt when ID_EX_PERF_EN is defined
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DW = 32
`ifdef ID_EX_PERF_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_id,
   input  logic [DW-1:0] pc4_id,
   input  logic [DW-1:0] rs_data_id,
   input  logic [DW-1:0] rt_data_id,
   input  logic [DW-1:0] imm_id,
   input  logic [4:0]    rs_id,
   input  logic [4:0]    rt_id,
   input  logic [4:0]    rd_id,
   input  logic          reg_write_id,
   input  logic          mem_read_id,
   input  logic          mem_write_id,
   input  logic          mem_to_reg_id,
   input  logic          alu_src_id,
   input  logic          reg_dst_id,
   input  logic [2:0]    alu_op_id,
   input  logic          uses_rt_id,
   input  logic          flush,
   input  logic          hold,
   output logic          valid_ex,
   output logic [DW-1:0] pc4_ex,
   output logic [DW-1:0] rs_data_ex,
   output logic [DW-1:0] rt_data_ex,
   output logic [DW-1:0] imm_ex,
   output logic [4:0]    rs_ex,
   output logic [4:0]    rt_ex,
   output logic [4:0]    rd_ex,
   output logic          reg_write_ex,
   output logic          mem_read_ex,
   output logic          mem_write_ex,
   output logic          mem_to_reg_ex,
   output logic          alu_src_ex,
   output logic          reg_dst_ex,
   output logic [2:0]    alu_op_ex,
   output logic          uses_rt_ex,
`ifdef ID_EX_PERF_EN
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt,
`endif
   output logic          load_use_stall
);
   ctrl_t ctrlId, ctrlEx;
   logic  bubble;

   assign ctrlId = '{regWrite: reg_write_id, memRead: mem_read_id, memWrite: mem_write_id,
                     memToReg: mem_to_reg_id, aluSrc: alu_src_id, regDst: reg_dst_id,
                     aluOp: alu_op_t'(alu_op_id)};

   load_use_detect uDetect (
      .valid_ex      (valid_ex),
      .mem_read_ex   (mem_read_ex),
      .rt_ex         (rt_ex),
      .valid_id      (valid_id),
      .rs_id         (rs_id),
      .rt_id         (rt_id),
      .uses_rt_id    (uses_rt_id),
      .flush         (flush),
      .hold          (hold),
      .load_use_stall(load_use_stall)
   );

   // load_use_stall is already forced low by flush, so either source zeroes the slot
   assign bubble = flush | load_use_stall;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         valid_ex   <= 1'b0;
         ctrlEx     <= '0;
         pc4_ex     <= '0;
         rs_data_ex <= '0;
         rt_data_ex <= '0;
         imm_ex     <= '0;
         rs_ex      <= '0;
         rt_ex      <= '0;
         rd_ex      <= '0;
         uses_rt_ex <= 1'b0;
      end else if (!hold) begin
         valid_ex   <= valid_id & ~bubble;
         ctrlEx     <= bubble ? '0 : ctrlId;
         pc4_ex     <= bubble ? '0 : pc4_id;
         rs_data_ex <= bubble ? '0 : rs_data_id;
         rt_data_ex <= bubble ? '0 : rt_data_id;
         imm_ex     <= bubble ? '0 : imm_id;
         rs_ex      <= bubble ? '0 : rs_id;
         rt_ex      <= bubble ? '0 : rt_id;
         rd_ex      <= bubble ? '0 : rd_id;
         uses_rt_ex <= ~bubble & uses_rt_id;
      end

   assign reg_write_ex  = ctrlEx.regWrite;
   assign mem_read_ex   = ctrlEx.memRead;
   assign mem_write_ex  = ctrlEx.memWrite;
   assign mem_to_reg_ex = ctrlEx.memToReg;
   assign alu_src_ex    = ctrlEx.aluSrc;
   assign reg_dst_ex    = ctrlEx.regDst;
   assign alu_op_ex     = ctrlEx.aluOp;

`ifdef ID_EX_PERF_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else if (!hold) begin
         if (flush) flush_cnt <= flush_cnt + 1'b1;
         if (load_use_stall) bubble_cnt <= bubble_cnt + 1'b1;
      end
`endif
endmodule
